// File: rtl/mem_handshake_unit_if.sv
// Memory-side bus of the memory-access stage: 4-phase req/ack handshake plus address/data.
// mem_req rises to start an access; memory raises mem_ack when done, mem_req then drops, and mem_ack must drop before the next request.
interface mem_handshake_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_handshake_unit.sv
// Memory-access stage: owns MAR/MDR and turns decoder MOV/RW into a 4-phase memory handshake.
// Emits a one-cycle MOC pulse on completion and a sticky err flag on timeout.
module mem_handshake_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mar_en,
    input  logic                 mdr_en,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [DATA_W-1:0]    wdata_in,
    input  logic                 mov,
    input  logic                 rw,
    mem_handshake_unit_if.master mem_bus,
    output logic                 moc,
    output logic [DATA_W-1:0]    mdr_out,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           dbg_state
);
    localparam int                 CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              rw_q, rw_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rw_d    = rw_q;
        moc_d   = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // Loads land in the same edge as mov, so the request carries the new values.
                if (mar_en) mar_d = addr_in;
                if (mdr_en) mdr_d = wdata_in;
                if (mov) begin
                    rw_d    = rw;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                if (mem_bus.mem_ack) begin
                    if (rw_q) mdr_d = mem_bus.mem_rdata;
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!mem_bus.mem_ack) begin
                    moc_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    assign mem_bus.mem_req   = req_q;
    assign mem_bus.mem_rw    = rw_q;
    assign mem_bus.mem_addr  = mar_q;
    assign mem_bus.mem_wdata = mdr_q;
    assign moc               = moc_q;
    assign mdr_out           = mdr_q;
    assign busy              = (state_q != IDLE);
    assign err               = err_q;
    assign dbg_state         = state_q;
endmodule

// File: doc/mem_handshake_unit.md
Name: mem_handshake_unit

Overview:
- Memory-access stage directly downstream of the main control decoder in the multi-cycle MIPS datapath.
- Owns the MAR and MDR registers.
- Turns the decoder's MOV / RW / MAREnable / MDREnable outputs into a 4-phase req/ack handshake with an external memory of variable latency.
- Returns a one-cycle MOC completion pulse to control, and a sticky error flag if memory never answers.

Parameters:
ADDR_W, 32, width of MAR and mem_addr
DATA_W, 32, width of MDR and data buses
TIMEOUT, 15, cycles to wait in ACCESS for mem_ack before aborting; must be >= 1

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-high
mar_en  in  1  load MAR from addr_in (honoured only in IDLE)
mdr_en  in  1  load MDR from wdata_in (honoured only in IDLE)
addr_in  in  ADDR_W  address from datapath
wdata_in  in  DATA_W  store data from datapath
mov  in  1  memory operation valid; start request (honoured only in IDLE)
rw  in  1  1 = read, 0 = write; sampled with mov
mem_req  out  1  request to memory
mem_rw  out  1  latched direction, stable while mem_req or RELEASE
mem_addr  out  ADDR_W  = MAR
mem_wdata  out  DATA_W  = MDR
mem_ack  in  1  memory acknowledge
mem_rdata  in  DATA_W  read data, valid while mem_ack = 1
moc  out  1  one-cycle completion pulse to control
mdr_out  out  DATA_W  = MDR
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous): state = IDLE; MAR = 0; MDR = 0; counter = 0; mem_req = 0; mem_rw = 0; moc = 0; err = 0; busy = 0. Reset mid-transaction aborts immediately: mem_req is low after that edge, no moc pulse.
- All outputs are registered or direct register values; no combinational path from inputs to outputs.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - mar_en = 1: MAR <= addr_in. mdr_en = 1: MDR <= wdata_in.
  - mov = 1:
    - mem_rw <= rw; err <= 0; counter <= 0; mem_req <= 1; go to ACCESS.
    - If mar_en / mdr_en are asserted in the same cycle, the new MAR/MDR values are the ones presented with the request.
- ACCESS:
  - mem_req = 1; counter increments each cycle.
  - mem_ack = 1: if mem_rw = 1, MDR <= mem_rdata; mem_req <= 0; go to RELEASE.
  - mem_ack = 0 and counter = TIMEOUT-1: err <= 1; mem_req <= 0; go to RELEASE.
  - Ack on the final counted cycle counts as success: ack has priority over timeout.
- RELEASE:
  - mem_req = 0; waits for mem_ack = 0.
  - When mem_ack = 0: moc <= 1 for exactly one cycle; go to IDLE.
  - No timeout in RELEASE.
- Latency:
  - mov sampled at edge N → mem_req high after N.
  - mem_ack first sampled high at edge M → MDR updated and mem_req low after M.
  - mem_ack sampled low at edge K → moc high and busy low after K.
  - Minimum: mov to moc is 3 cycles, with ack lasting one cycle.
- Ignored while busy: mar_en, mdr_en and mov are ignored outside IDLE. There is no queuing; control must wait for moc.
- MAR and MDR are unchanged by write transactions. MDR is unchanged on a timed-out read.
- Counter width is clog2(TIMEOUT)+1; it saturates and never wraps.
- err stays set until the next accepted mov or reset.

Test Plan:
- Read: mar_en=1, addr_in=0x100, then mov=1, rw=1; memory acks 3 cycles after req with rdata=0xDEADBEEF, then drops ack → mem_addr=0x100, mem_rw=1, mdr_out=0xDEADBEEF, single moc pulse, err=0, busy low same cycle as moc.
- Write with same-cycle load: mar_en=1, mdr_en=1, mov=1, rw=0 in one cycle, addr_in=0x40, wdata_in=0x12345678 → mem_addr=0x40, mem_wdata=0x12345678, mem_rw=0 from first req cycle; MDR unchanged after ack.
- Timeout: mov=1 with mem_ack held 0 → mem_req high exactly 15 cycles then low, err=1, moc pulses once; next mov clears err.
- Ack on 15th ACCESS cycle → success: MDR captured, err=0.
- Ignored while busy: pulse mov, mar_en (addr_in=0xFFF) and mdr_en during ACCESS → no second transaction, MAR/MDR unchanged, exactly one moc.
- Reset mid-op: assert reset in ACCESS → mem_req=0, busy=0, moc=0, err=0, MAR=MDR=0 after edge; a late mem_ack pulse afterward is ignored.
